// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle RV32I-subset control unit.
// Holds the FSM state enum, the supported opcodes, and the field encodings
// driven onto the datapath mux selects.
package multicycle_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_I, EXEC_R, ALU_WB,
        MEM_ADR, MEM_RD, MEM_WB, MEM_WR, BRANCH
    } state_t;

    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BNE  = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath bundle.
//   master (control unit): takes instr/EQ/mem_ready, drives all selects,
//                          enables, mem_req and the instr_done/fault pulses.
//   slave  (datapath/memory side): the mirror image.
interface multicycle_control_if #(parameter int instr_width = 32);
    logic [instr_width-1:0] instr;
    logic                   EQ;
    logic                   mem_ready;
    logic                   mem_req;
    logic                   AdrSrc;
    logic                   IRWrite;
    logic                   PCWrite;
    logic                   PCsrc;
    logic                   RegWrite;
    logic                   MemWrite;
    logic [1:0]             ImmSrc;
    logic [1:0]             ALUsrcA;
    logic [1:0]             ALUsrcB;
    logic [2:0]             ALUctrl;
    logic [1:0]             ResultSrc;
    logic                   instr_done;
    logic                   fault;

    modport master (
        input  instr, EQ, mem_ready,
        output mem_req, AdrSrc, IRWrite, PCWrite, PCsrc, RegWrite, MemWrite,
               ImmSrc, ALUsrcA, ALUsrcB, ALUctrl, ResultSrc, instr_done, fault
    );

    modport slave (
        output instr, EQ, mem_ready,
        input  mem_req, AdrSrc, IRWrite, PCWrite, PCsrc, RegWrite, MemWrite,
               ImmSrc, ALUsrcA, ALUsrcB, ALUctrl, ResultSrc, instr_done, fault
    );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// ALU operation decoder (combinational).
//   funct3, funct7b5 (instr[30]), is_rtype in; alu_ctrl out.
// Only R-type funct3=000 with funct7[5] set selects subtract; everything
// else in this subset is an add.
module alu_decoder
    import multicycle_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_rtype,
    output logic [2:0] alu_ctrl
);
    always_comb begin
        alu_ctrl = ALU_ADD;
        if (is_rtype && funct3 == 3'b000 && funct7b5)
            alu_ctrl = ALU_SUB;
    end
endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle RV32I-subset datapath
// (addi, add/sub, lw, sw, bne).
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset
//   bus  : multicycle_control_if.master (instr/EQ/mem_ready in, all
//          selects, enables, mem_req, instr_done, fault out)
// Outputs decode from state; FETCH write enables and BRANCH PCWrite are
// also qualified by inputs. Memory states stall on mem_ready and abort to
// FETCH with a fault pulse after TIMEOUT_CYCLES waiting cycles.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int instr_width    = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    multicycle_control_if.master bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [6:0]    opcode;
    logic [2:0]    alu_ctrl_r;
    logic          wait_st;
    logic          timeout;
    logic          legal;

    assign opcode  = bus.instr[6:0];
    assign wait_st = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    // A late mem_ready on the limit cycle still completes the access.
    assign timeout = wait_st && !bus.mem_ready && (wait_cnt == CW'(TIMEOUT_CYCLES));
    assign legal   = (opcode == OP_ADDI) || (opcode == OP_R) || (opcode == OP_LW) ||
                     (opcode == OP_SW) || (opcode == OP_BNE);

    alu_decoder u_alu_dec (
        .funct3   (bus.instr[14:12]),
        .funct7b5 (bus.instr[30]),
        .is_rtype (opcode == OP_R),
        .alu_ctrl (alu_ctrl_r)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= FETCH;
            wait_cnt <= '0;
        end else begin
            // Counter only runs while stalled in a memory state.
            if (!wait_st || bus.mem_ready || timeout) wait_cnt <= '0;
            else                                     wait_cnt <= wait_cnt + 1'b1;

            case (state)
                FETCH:   if (bus.mem_ready) state <= DECODE;
                DECODE: begin
                    case (opcode)
                        OP_ADDI:      state <= EXEC_I;
                        OP_R:         state <= EXEC_R;
                        OP_LW, OP_SW: state <= MEM_ADR;
                        OP_BNE:       state <= BRANCH;
                        default:      state <= FETCH;
                    endcase
                end
                EXEC_I, EXEC_R: state <= ALU_WB;
                MEM_ADR: state <= (opcode == OP_LW) ? MEM_RD : MEM_WR;
                MEM_RD: begin
                    if (bus.mem_ready)  state <= MEM_WB;
                    else if (timeout)   state <= FETCH;
                end
                MEM_WR:  if (bus.mem_ready || timeout) state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        bus.mem_req    = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.PCWrite    = 1'b0;
        bus.PCsrc      = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.ImmSrc     = IMM_I;
        bus.ALUsrcA    = SRCA_PC;
        bus.ALUsrcB    = SRCB_RS2;
        bus.ALUctrl    = ALU_ADD;
        bus.ResultSrc  = RES_ALUOUT;
        bus.instr_done = 1'b0;
        bus.fault      = 1'b0;
        // Everything held low during reset so no write escapes mid-instruction.
        if (rst) begin
            case (state)
                FETCH: begin
                    bus.mem_req   = 1'b1;
                    bus.ALUsrcB   = SRCB_FOUR;
                    bus.ResultSrc = RES_ALU;
                    bus.IRWrite   = bus.mem_ready;
                    bus.PCWrite   = bus.mem_ready;
                    bus.fault     = timeout;
                end
                DECODE: begin
                    bus.ALUsrcA = SRCA_OLDPC;
                    bus.ALUsrcB = SRCB_IMM;
                    bus.ImmSrc  = IMM_B;
                    bus.fault   = !legal;
                end
                EXEC_I: begin
                    bus.ALUsrcA = SRCA_RS1;
                    bus.ALUsrcB = SRCB_IMM;
                end
                EXEC_R: begin
                    bus.ALUsrcA = SRCA_RS1;
                    bus.ALUctrl = alu_ctrl_r;
                end
                ALU_WB: begin
                    bus.RegWrite   = 1'b1;
                    bus.instr_done = 1'b1;
                end
                MEM_ADR: begin
                    bus.ALUsrcA = SRCA_RS1;
                    bus.ALUsrcB = SRCB_IMM;
                    bus.ImmSrc  = (opcode == OP_SW) ? IMM_S : IMM_I;
                end
                MEM_RD: begin
                    bus.mem_req = 1'b1;
                    bus.AdrSrc  = 1'b1;
                    bus.fault   = timeout;
                end
                MEM_WB: begin
                    bus.ResultSrc  = RES_RDATA;
                    bus.RegWrite   = 1'b1;
                    bus.instr_done = 1'b1;
                end
                MEM_WR: begin
                    bus.mem_req    = 1'b1;
                    bus.MemWrite   = 1'b1;
                    bus.AdrSrc     = 1'b1;
                    bus.instr_done = bus.mem_ready;
                    bus.fault      = timeout;
                end
                BRANCH: begin
                    bus.ALUsrcA    = SRCA_RS1;
                    bus.ALUctrl    = ALU_SUB;
                    bus.PCsrc      = 1'b1;
                    bus.PCWrite    = !bus.EQ;
                    bus.instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control (TIMEOUT_CYCLES = 4).
// Each driven cycle pushes the full expected output vector; the negedge
// monitor pops and compares it against the DUT outputs.
module tb_multicycle_control;
    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_SUB  = 32'h40000033;
    localparam logic [31:0] I_ADD  = 32'h00000033;
    localparam logic [31:0] I_SLL  = 32'h40001033;
    localparam logic [31:0] I_LW   = 32'h00002003;
    localparam logic [31:0] I_SW   = 32'h00002023;
    localparam logic [31:0] I_BNE  = 32'h00001063;
    localparam logic [31:0] I_BAD  = 32'h0000007F;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    multicycle_control_if #(.instr_width(32)) bus ();
    multicycle_control #(.instr_width(32), .TIMEOUT_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    logic [19:0] exp_q[$];
    string       tag_q[$];

    wire [19:0] outv = {bus.mem_req, bus.AdrSrc, bus.IRWrite, bus.PCWrite, bus.PCsrc,
                        bus.RegWrite, bus.MemWrite, bus.ImmSrc, bus.ALUsrcA, bus.ALUsrcB,
                        bus.ALUctrl, bus.ResultSrc, bus.instr_done, bus.fault};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) chk(tag_q.pop_front(), 32'(outv), 32'(exp_q.pop_front()));
    end

    // Expected vector, field order matches outv.
    function automatic logic [19:0] v(input logic mreq, adr, irw, pcw, pcs, rw, mw,
                                      input logic [1:0] imm, sa, sb, input logic [2:0] ctl,
                                      input logic [1:0] rs, input logic done, flt);
        return {mreq, adr, irw, pcw, pcs, rw, mw, imm, sa, sb, ctl, rs, done, flt};
    endfunction

    function automatic logic [19:0] f_fetch(input logic r, flt);
        return v(1, 0, r, r, 0, 0, 0, 2'b00, 2'b00, 2'b10, 3'b000, 2'b10, 0, flt);
    endfunction
    function automatic logic [19:0] f_dec(input logic flt);
        return v(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b01, 3'b000, 2'b00, 0, flt);
    endfunction
    function automatic logic [19:0] f_exi();
        return v(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0);
    endfunction
    function automatic logic [19:0] f_exr(input logic [2:0] ctl);
        return v(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, ctl, 2'b00, 0, 0);
    endfunction
    function automatic logic [19:0] f_wb(input logic [1:0] rs);
        return v(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, rs, 1, 0);
    endfunction
    function automatic logic [19:0] f_adr(input logic [1:0] imm);
        return v(0, 0, 0, 0, 0, 0, 0, imm, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0);
    endfunction
    function automatic logic [19:0] f_rd(input logic flt);
        return v(1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, flt);
    endfunction
    function automatic logic [19:0] f_wr(input logic done, flt);
        return v(1, 1, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, done, flt);
    endfunction
    function automatic logic [19:0] f_br(input logic eq);
        return v(0, 0, 0, !eq, 1, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00, 1, 0);
    endfunction

    task automatic step(input string tag, input logic r, input logic [31:0] ins,
                        input logic eq, input logic rdy, input logic [19:0] e);
        @(posedge clk);
        #1;
        rst = r;
        bus.instr = ins;
        bus.EQ = eq;
        bus.mem_ready = rdy;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic do_fetch(input string t, input logic [31:0] ins, input int stalls);
        for (int i = 0; i < stalls; i++) step({t, "_fstall"}, 1, ins, 0, 0, f_fetch(0, 0));
        step({t, "_fetch"}, 1, ins, 0, 1, f_fetch(1, 0));
        step({t, "_dec"}, 1, ins, 0, 1, f_dec(0));
    endtask

    task automatic do_alu(input string t, input logic [31:0] ins, input logic isr,
                          input logic [2:0] ctl);
        do_fetch(t, ins, 0);
        step({t, "_exec"}, 1, ins, 0, 1, isr ? f_exr(ctl) : f_exi());
        step({t, "_wb"}, 1, ins, 0, 1, f_wb(2'b00));
    endtask

    task automatic do_lw(input string t, input int fstalls, input int stalls);
        do_fetch(t, I_LW, fstalls);
        step({t, "_adr"}, 1, I_LW, 0, 1, f_adr(2'b00));
        for (int i = 0; i < stalls; i++) step({t, "_rdstall"}, 1, I_LW, 0, 0, f_rd(0));
        step({t, "_rd"}, 1, I_LW, 0, 1, f_rd(0));
        step({t, "_wb"}, 1, I_LW, 0, 1, f_wb(2'b01));
    endtask

    task automatic do_bne(input string t, input logic eq);
        do_fetch(t, I_BNE, 0);
        step({t, "_br"}, 1, I_BNE, eq, 1, f_br(eq));
    endtask

    initial begin
        bus.instr = '0;
        bus.EQ = 1'b0;
        bus.mem_ready = 1'b0;

        step("reset0", 0, I_ADDI, 0, 1, '0);
        step("reset1", 0, I_ADDI, 0, 1, '0);

        do_alu("addi", I_ADDI, 0, 3'b000);
        do_alu("sub", I_SUB, 1, 3'b001);
        do_alu("add", I_ADD, 1, 3'b000);
        do_alu("f3ne0", I_SLL, 1, 3'b000);

        do_lw("lw3", 0, 3);

        do_fetch("sw", I_SW, 0);
        step("sw_adr", 1, I_SW, 0, 1, f_adr(2'b01));
        step("sw_wr", 1, I_SW, 0, 1, f_wr(1, 0));

        do_bne("bne_ne", 0);
        do_bne("bne_eq", 1);

        do_fetch("illegal", I_BAD, 0);
        // DECODE of the illegal opcode must carry the fault pulse.
        exp_q[exp_q.size()-1] = f_dec(1);

        // FETCH timeout: limit reached on the 5th stalled cycle.
        for (int i = 0; i < 4; i++) step("fto_wait", 1, I_ADDI, 0, 0, f_fetch(0, 0));
        step("fto_fault", 1, I_ADDI, 0, 0, f_fetch(0, 1));
        do_alu("after_fto", I_ADDI, 0, 3'b000);

        // Counter clears between states; ready on the limit cycle wins.
        do_lw("lw4", 3, 4);

        // MEM_WR timeout.
        do_fetch("swto", I_SW, 0);
        step("swto_adr", 1, I_SW, 0, 1, f_adr(2'b01));
        for (int i = 0; i < 4; i++) step("swto_wait", 1, I_SW, 0, 0, f_wr(0, 0));
        step("swto_fault", 1, I_SW, 0, 0, f_wr(0, 1));
        do_alu("after_swto", I_ADDI, 0, 3'b000);

        // Reset while in MEM_WR.
        do_fetch("swrst", I_SW, 0);
        step("swrst_adr", 1, I_SW, 0, 1, f_adr(2'b01));
        step("swrst_wr", 1, I_SW, 0, 0, f_wr(0, 0));
        step("swrst_rst", 0, I_SW, 0, 1, '0);
        do_alu("after_rst", I_ADDI, 0, 3'b000);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style FSM that sequences the multicycle RV32I-subset datapath: shared ALU, single unified memory, instruction register (IR), PC register and ALUOut register.
- Supported instructions:
  - addi (opcode 0010011)
  - R-type add/sub (0110011)
  - lw (0000011)
  - sw (0100011)
  - bne (1100011)
- Drives all mux selects and write enables.
- Stalls on a memory ready handshake and aborts a hung access after a timeout.

Parameters:
- instr_width, 32, IR width.
- TIMEOUT_CYCLES, 255, maximum cycles spent waiting for mem_ready before abort; must be at least 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; synchronous, active-low.
- instr  input  instr_width  current IR contents. Uses opcode [6:0], funct3 [14:12], funct7[5] (bit 30).
- EQ  input  1  ALU zero/equal flag from the rs1/rs2 compare.
- mem_ready  input  1  memory has completed the current request this cycle.
- mem_req  output  1  memory access request; held high until mem_ready.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  output  1  load IR from memory read data.
- PCWrite  output  1  load PC.
- PCsrc  output  1  PC source: 0 = ALU result, 1 = ALUOut (branch target).
- RegWrite  output  1  register file write enable.
- MemWrite  output  1  store qualifier; valid with mem_req.
- ImmSrc  output  2  immediate format: 00 = I, 01 = S, 10 = B.
- ALUsrcA  output  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1.
- ALUsrcB  output  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4.
- ALUctrl  output  3  ALU operation: 000 = add, 001 = sub.
- ResultSrc  output  2  writeback source: 00 = ALUOut, 01 = read data, 10 = ALU result.
- instr_done  output  1  one-cycle pulse when an instruction retires.
- fault  output  1  one-cycle pulse on an illegal opcode or a memory timeout.

Behaviour:
- Reset:
  - rst low at a clock edge sets state to FETCH and clears the timeout counter.
  - While rst is low, every output is forced to 0.
- Outputs are combinational from state. Exceptions: IRWrite/PCWrite in FETCH and PCWrite in BRANCH are also qualified by inputs. All unlisted outputs are 0.
- FETCH:
  - mem_req=1, AdrSrc=0, ALUsrcA=00, ALUsrcB=10, ALUctrl=000, ResultSrc=10, PCsrc=0.
  - When mem_ready=1: IRWrite=1, PCWrite=1 (PC <= PC+4), then go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - ALUsrcA=01, ALUsrcB=01, ImmSrc=10, ALUctrl=000; branch target is latched into ALUOut.
  - Next state by opcode:
    - addi goes to EXEC_I.
    - R-type goes to EXEC_R.
    - lw/sw go to MEM_ADR.
    - bne goes to BRANCH.
    - Any other opcode goes to FETCH with fault=1.
- EXEC_I: ALUsrcA=10, ALUsrcB=01, ImmSrc=00, ALUctrl=000; go to ALU_WB.
- EXEC_R: ALUsrcA=10, ALUsrcB=00, ALUctrl from funct3/funct7 (funct3=000: funct7[5]=1 gives sub, else add); go to ALU_WB.
- ALU_WB: ResultSrc=00, RegWrite=1, instr_done=1; go to FETCH.
- MEM_ADR: ALUsrcA=10, ALUsrcB=01, ImmSrc=00 for lw / 01 for sw, ALUctrl=000; lw goes to MEM_RD, sw goes to MEM_WR.
- MEM_RD: mem_req=1, AdrSrc=1; on mem_ready go to MEM_WB.
- MEM_WB: ResultSrc=01, RegWrite=1, instr_done=1; go to FETCH.
- MEM_WR:
  - mem_req=1, MemWrite=1, AdrSrc=1.
  - On mem_ready: instr_done=1, go to FETCH.
- BRANCH:
  - ALUsrcA=10, ALUsrcB=00, ALUctrl=001, PCsrc=1.
  - PCWrite=EQ==0. instr_done=1. Go to FETCH.
- Latency with mem_ready tied high:
  - addi/R-type: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - bne: 3 cycles.
  - Each cycle of mem_ready=0 in a memory state adds one cycle.
- Timeout:
  - The counter increments each cycle in FETCH/MEM_RD/MEM_WR with mem_ready=0, and clears on leaving those states.
  - When the counter reaches TIMEOUT_CYCLES with mem_ready still 0:
    - pulse fault=1 and go to FETCH;
    - no IRWrite/PCWrite/RegWrite is issued;
    - PC is unchanged.
  - If mem_ready=1 arrives in the same cycle as the limit, mem_ready wins.
- Reset asserted mid-instruction: abandon the instruction, with no partial writes after the reset edge.
- Counter width: clog2(TIMEOUT_CYCLES+1).

Decomposition:
- multicycle_pkg contains:
  - state enum;
  - opcode constants;
  - ALUctrl codes;
  - ImmSrc, ALUsrcA, ALUsrcB and ResultSrc encodings.
- Sub-module alu_decoder (combinational): funct3, funct7[5] and an R-type flag in, ALUctrl out. Instantiated once.

Test Plan:
- addi x1,x0,5 (0x00500093), mem_ready=1 -> states FETCH, DECODE, EXEC_I, ALU_WB; RegWrite=1 only in cycle 4; instr_done pulse in cycle 4.
- sub (funct7[5]=1, opcode 0110011) -> ALUctrl=001 in EXEC_R; add (funct7[5]=0) -> ALUctrl=000.
- lw with mem_ready low for 3 cycles in MEM_RD -> 8 total cycles; mem_req held high; RegWrite=1 with ResultSrc=01 in the final cycle.
- bne with EQ=0 -> PCWrite=1, PCsrc=1 in cycle 3; with EQ=1 -> PCWrite=0 and still back in FETCH.
- Opcode 1111111 -> fault pulse in DECODE; no RegWrite/MemWrite; back in FETCH next cycle.
- TIMEOUT_CYCLES=4 with mem_ready stuck low in FETCH -> fault at cycle 5; no IRWrite. Separately, rst=0 during MEM_WR -> all outputs 0 and FETCH after reset release.
